// File: rtl/ex_operand_stage_if.sv
// ID/EX operand-stage bus: decoded ID fields, forwarding sources and registered EX outputs.
interface ex_operand_stage_if #(
  parameter int XLEN = 64,
  parameter int REGW = 5
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [REGW-1:0] id_rs1, id_rs2, id_rd;
  logic [1:0]      id_aluop;
  logic [2:0]      id_funct3;
  logic            id_funct7_5, id_alusrc, id_regwrite, id_memread;
  logic            id_memwrite, id_memtoreg, id_branch;
  logic            exmem_regwrite, memwb_regwrite;
  logic [REGW-1:0] exmem_rd, memwb_rd;
  logic [XLEN-1:0] exmem_result, memwb_result;
  logic            ex_valid;
  logic [XLEN-1:0] ex_a, ex_b, ex_store_data, ex_pc;
  logic [3:0]      ex_alu_control;
  logic [REGW-1:0] ex_rd;
  logic            ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch;
  logic            ex_decode_err, load_use_stall;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_aluop, id_funct3, id_funct7_5, id_alusrc, id_regwrite, id_memread,
           id_memwrite, id_memtoreg, id_branch,
           exmem_regwrite, exmem_rd, exmem_result, memwb_regwrite, memwb_rd, memwb_result,
    input  ex_valid, ex_a, ex_b, ex_store_data, ex_pc, ex_alu_control, ex_rd,
           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch,
           ex_decode_err, load_use_stall
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_aluop, id_funct3, id_funct7_5, id_alusrc, id_regwrite, id_memread,
           id_memwrite, id_memtoreg, id_branch,
           exmem_regwrite, exmem_rd, exmem_result, memwb_regwrite, memwb_rd, memwb_result,
    output ex_valid, ex_a, ex_b, ex_store_data, ex_pc, ex_alu_control, ex_rd,
           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch,
           ex_decode_err, load_use_stall
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX stage ahead of the RV64 ALU: registers decode fields, builds ALU control,
// forwards operands from EX/MEM and MEM/WB, and flags load-use hazards.
module ex_fwd_lane #(
  parameter int XLEN = 64,
  parameter int REGW = 5
) (
  input  logic [REGW-1:0] rs,
  input  logic [XLEN-1:0] data,
  input  logic            exmem_regwrite,
  input  logic [REGW-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_regwrite,
  input  logic [REGW-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] fwd
);
  always_comb begin
    fwd = data;
    if (exmem_regwrite && exmem_rd != '0 && exmem_rd == rs)      fwd = exmem_result;
    else if (memwb_regwrite && memwb_rd != '0 && memwb_rd == rs) fwd = memwb_result;
  end
endmodule

module ex_operand_stage #(
  parameter int XLEN = 64,
  parameter int REGW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stall,
  input  logic           flush,
  ex_operand_stage_if.slave bus
);
  typedef struct packed {
    logic regwrite, memread, memwrite, memtoreg, branch;
  } ctrl_t;

  logic                       valid_q, alusrc_q, dec_err_q, dec_err_d;
  logic [XLEN-1:0]            pc_q, imm_q;
  logic [REGW-1:0]            rd_q;
  logic [3:0]                 alu_ctl_q, alu_ctl_d;
  logic [1:0][XLEN-1:0]       rs_data_q, fwd;
  logic [1:0][REGW-1:0]       rs_idx_q;
  ctrl_t                      ctrl_q, id_ctrl;

  assign id_ctrl = {bus.id_regwrite, bus.id_memread, bus.id_memwrite,
                    bus.id_memtoreg, bus.id_branch};

  always_comb begin
    alu_ctl_d = 4'b0010;
    dec_err_d = 1'b0;
    case (bus.id_aluop)
      2'b01: case (bus.id_funct3)
        3'b000, 3'b001: alu_ctl_d = 4'b0110;
        3'b100, 3'b101: alu_ctl_d = 4'b0111;
        3'b110, 3'b111: alu_ctl_d = 4'b1100;
        default: begin
          alu_ctl_d = 4'b1111;
          dec_err_d = 1'b1;
        end
      endcase
      2'b10, 2'b11: case (bus.id_funct3)
        // immediate forms have no SUB; instr[30] there is part of the immediate
        3'b000: alu_ctl_d = (bus.id_funct7_5 && bus.id_aluop == 2'b10) ? 4'b0110 : 4'b0010;
        3'b001: alu_ctl_d = 4'b1001;
        3'b010: alu_ctl_d = 4'b0111;
        3'b011: alu_ctl_d = 4'b1100;
        3'b100: alu_ctl_d = 4'b1000;
        3'b101: alu_ctl_d = bus.id_funct7_5 ? 4'b1011 : 4'b1010;
        3'b110: alu_ctl_d = 4'b0001;
        default: alu_ctl_d = 4'b0000;
      endcase
      default: alu_ctl_d = 4'b0010;
    endcase
  end

  for (genvar l = 0; l < 2; l++) begin : g_fwd
    ex_fwd_lane #(.XLEN(XLEN), .REGW(REGW)) u_fwd (
      .rs             (rs_idx_q[l]),
      .data           (rs_data_q[l]),
      .exmem_regwrite (bus.exmem_regwrite),
      .exmem_rd       (bus.exmem_rd),
      .exmem_result   (bus.exmem_result),
      .memwb_regwrite (bus.memwb_regwrite),
      .memwb_rd       (bus.memwb_rd),
      .memwb_result   (bus.memwb_result),
      .fwd            (fwd[l])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      alusrc_q  <= 1'b0;
      dec_err_q <= 1'b0;
      pc_q      <= '0;
      imm_q     <= '0;
      rd_q      <= '0;
      alu_ctl_q <= 4'b0000;
      rs_data_q <= '0;
      rs_idx_q  <= '0;
      ctrl_q    <= '0;
    end else if (flush) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      dec_err_q <= 1'b0;
      rd_q      <= '0;
    end else if (stall) begin
      // capture forwarded operands so they survive the producer leaving WB
      rs_data_q <= fwd;
    end else begin
      valid_q   <= bus.id_valid;
      alusrc_q  <= bus.id_alusrc;
      dec_err_q <= bus.id_valid & dec_err_d;
      pc_q      <= bus.id_pc;
      imm_q     <= bus.id_imm;
      rd_q      <= bus.id_rd;
      alu_ctl_q <= alu_ctl_d;
      rs_data_q <= {bus.id_rs2_data, bus.id_rs1_data};
      rs_idx_q  <= {bus.id_rs2, bus.id_rs1};
      ctrl_q    <= bus.id_valid ? id_ctrl : '0;
    end
  end

  assign bus.ex_valid       = valid_q;
  assign bus.ex_a           = fwd[0];
  assign bus.ex_b           = alusrc_q ? imm_q : fwd[1];
  assign bus.ex_store_data  = fwd[1];
  assign bus.ex_alu_control = alu_ctl_q;
  assign bus.ex_pc          = pc_q;
  assign bus.ex_rd          = rd_q;
  assign bus.ex_regwrite    = ctrl_q.regwrite;
  assign bus.ex_memread     = ctrl_q.memread;
  assign bus.ex_memwrite    = ctrl_q.memwrite;
  assign bus.ex_memtoreg    = ctrl_q.memtoreg;
  assign bus.ex_branch      = ctrl_q.branch;
  assign bus.ex_decode_err  = dec_err_q;

  assign bus.load_use_stall = valid_q & ctrl_q.memread & (rd_q != '0) & bus.id_valid &
                              ((bus.id_rs1 == rd_q) | ((bus.id_rs2 == rd_q) & ~bus.id_alusrc));
endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage; expectations queued at drive time, checked after edge/settle.
module tb_ex_operand_stage;
  localparam int XLEN = 64;
  localparam int REGW = 5;

  typedef struct {
    int          sel;
    logic [63:0] exp;
    string       tag;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, flush = 1'b0;
  int   checks = 0, errors = 0;
  exp_t sbq[$];

  ex_operand_stage_if #(.XLEN(XLEN), .REGW(REGW)) bus ();
  ex_operand_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  localparam int S_VALID = 0, S_A = 1, S_B = 2, S_ST = 3, S_CTL = 4, S_ERR = 5,
                 S_LUS = 6, S_CTRLS = 7, S_RD = 8, S_PC = 9;

  function automatic logic [63:0] obs(input int sel);
    case (sel)
      S_VALID: return 64'(bus.ex_valid);
      S_A:     return bus.ex_a;
      S_B:     return bus.ex_b;
      S_ST:    return bus.ex_store_data;
      S_CTL:   return 64'(bus.ex_alu_control);
      S_ERR:   return 64'(bus.ex_decode_err);
      S_LUS:   return 64'(bus.load_use_stall);
      S_CTRLS: return 64'({bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite,
                           bus.ex_memtoreg, bus.ex_branch});
      S_RD:    return 64'(bus.ex_rd);
      default: return bus.ex_pc;
    endcase
  endfunction

  task automatic expect_v(input int sel, input logic [63:0] e, input string tag);
    exp_t t;
    t.sel = sel;
    t.exp = e;
    t.tag = tag;
    sbq.push_back(t);
  endtask

  task automatic drain();
    while (sbq.size() > 0) begin
      exp_t t;
      logic [63:0] o;
      t = sbq.pop_front();
      o = obs(t.sel);
      checks++;
      assert (o === t.exp) else begin
        errors++;
        $error("FAIL %s observed %0h expected %0h", t.tag, o, t.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  task automatic clr_id();
    bus.id_valid = 0; bus.id_pc = '0; bus.id_rs1_data = '0; bus.id_rs2_data = '0;
    bus.id_imm = '0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0;
    bus.id_aluop = 2'b00; bus.id_funct3 = 3'b000; bus.id_funct7_5 = 0;
    bus.id_alusrc = 0; bus.id_regwrite = 0; bus.id_memread = 0;
    bus.id_memwrite = 0; bus.id_memtoreg = 0; bus.id_branch = 0;
  endtask

  task automatic clr_fwd();
    bus.exmem_regwrite = 0; bus.exmem_rd = '0; bus.exmem_result = '0;
    bus.memwb_regwrite = 0; bus.memwb_rd = '0; bus.memwb_result = '0;
  endtask

  initial begin
    clr_id();
    clr_fwd();
    // reset
    bus.id_valid = 1; bus.id_regwrite = 1; bus.id_rs1_data = 64'h5;
    expect_v(S_VALID, 0, "rst_valid");
    expect_v(S_CTL, 0, "rst_ctl");
    expect_v(S_A, 0, "rst_a");
    expect_v(S_CTRLS, 0, "rst_ctrls");
    tick();
    rst = 0;
    clr_id();

    // R-type SUB
    bus.id_valid = 1; bus.id_aluop = 2'b10; bus.id_funct7_5 = 1; bus.id_pc = 64'h100;
    bus.id_rs1 = 1; bus.id_rs2 = 2; bus.id_rd = 3; bus.id_regwrite = 1;
    bus.id_rs1_data = 64'd10; bus.id_rs2_data = 64'd3;
    expect_v(S_CTL, 4'b0110, "sub_ctl");
    expect_v(S_A, 10, "sub_a");
    expect_v(S_B, 3, "sub_b");
    expect_v(S_VALID, 1, "sub_valid");
    expect_v(S_CTRLS, 5'b10000, "sub_ctrls");
    expect_v(S_PC, 64'h100, "sub_pc");
    tick();

    // SRAI and ADDI with instr[30] set
    bus.id_aluop = 2'b11; bus.id_funct3 = 3'b101; bus.id_imm = 64'd4; bus.id_alusrc = 1;
    bus.id_rs2_data = 64'h55;
    expect_v(S_CTL, 4'b1011, "srai_ctl");
    expect_v(S_B, 4, "srai_b");
    expect_v(S_ST, 64'h55, "srai_store");
    tick();
    bus.id_funct3 = 3'b000;
    expect_v(S_CTL, 4'b0010, "addi_ctl");
    tick();

    // forwarding on rs1
    clr_id();
    bus.id_valid = 1; bus.id_aluop = 2'b10; bus.id_funct3 = 3'b111;
    bus.id_rs1 = 5; bus.id_rs1_data = 64'h1234;
    expect_v(S_A, 64'h1234, "fwd_none");
    expect_v(S_CTL, 4'b0000, "and_ctl");
    tick();
    bus.exmem_regwrite = 1; bus.exmem_rd = 5; bus.exmem_result = 64'hAAAA;
    bus.memwb_regwrite = 1; bus.memwb_rd = 5; bus.memwb_result = 64'hBBBB;
    expect_v(S_A, 64'hAAAA, "fwd_exmem_prio");
    settle();
    bus.exmem_rd = 0;
    expect_v(S_A, 64'hBBBB, "fwd_memwb");
    settle();
    clr_fwd();
    bus.id_rs1 = 0; bus.id_rs1_data = 64'h99;
    tick();
    bus.exmem_regwrite = 1; bus.exmem_rd = 0; bus.exmem_result = 64'hAAAA;
    bus.memwb_regwrite = 1; bus.memwb_rd = 0; bus.memwb_result = 64'hBBBB;
    expect_v(S_A, 64'h99, "fwd_x0");
    settle();
    clr_fwd();

    // stall keeps forwarded rs2 alive
    clr_id();
    bus.id_valid = 1; bus.id_aluop = 2'b10; bus.id_rs2 = 6; bus.id_rs2_data = 64'h10;
    bus.id_rd = 9; bus.id_regwrite = 1; bus.id_pc = 64'h200;
    expect_v(S_ST, 64'h10, "st_pre");
    tick();
    stall = 1;
    bus.memwb_regwrite = 1; bus.memwb_rd = 6; bus.memwb_result = 64'h77;
    bus.id_pc = 64'h300; bus.id_rs2_data = 64'h55; bus.id_rd = 4;
    expect_v(S_ST, 64'h77, "st_fwd");
    expect_v(S_B, 64'h77, "st_b");
    settle();
    expect_v(S_PC, 64'h200, "stall_pc_hold");
    expect_v(S_RD, 9, "stall_rd_hold");
    tick();
    bus.memwb_regwrite = 0;
    expect_v(S_ST, 64'h77, "st_after_src_gone");
    settle();
    expect_v(S_ST, 64'h77, "st_held_2");
    tick();

    // flush beats stall
    flush = 1;
    expect_v(S_VALID, 0, "flush_valid");
    expect_v(S_CTRLS, 0, "flush_ctrls");
    expect_v(S_RD, 0, "flush_rd");
    tick();
    flush = 0; stall = 0;
    clr_fwd();

    // load-use
    clr_id();
    bus.id_valid = 1; bus.id_memread = 1; bus.id_regwrite = 1; bus.id_rd = 7;
    bus.id_alusrc = 1;
    tick();
    clr_id();
    bus.id_valid = 1; bus.id_rs1 = 7;
    expect_v(S_LUS, 1, "lus_rs1");
    settle();
    bus.id_rs1 = 1; bus.id_rs2 = 7; bus.id_alusrc = 1;
    expect_v(S_LUS, 0, "lus_rs2_imm");
    settle();
    bus.id_alusrc = 0;
    expect_v(S_LUS, 1, "lus_rs2_reg");
    settle();
    bus.id_valid = 0;
    expect_v(S_LUS, 0, "lus_id_invalid");
    settle();
    clr_id();
    bus.id_valid = 1; bus.id_memread = 1; bus.id_rd = 0;
    tick();
    clr_id();
    bus.id_valid = 1;
    expect_v(S_LUS, 0, "lus_rd0");
    settle();

    // illegal branch funct3, then a clean ADD
    clr_id();
    bus.id_valid = 1; bus.id_aluop = 2'b01; bus.id_funct3 = 3'b010; bus.id_branch = 1;
    expect_v(S_CTL, 4'b1111, "br_bad_ctl");
    expect_v(S_ERR, 1, "br_bad_err");
    tick();
    bus.id_funct3 = 3'b110;
    expect_v(S_CTL, 4'b1100, "bltu_ctl");
    expect_v(S_ERR, 0, "bltu_err");
    tick();
    clr_id();
    bus.id_valid = 1; bus.id_regwrite = 1;
    expect_v(S_ERR, 0, "add_err");
    expect_v(S_CTL, 4'b0010, "add_ctl");
    tick();

    // invalid ID masks controls
    bus.id_valid = 0; bus.id_memwrite = 1;
    expect_v(S_VALID, 0, "bubble_valid");
    expect_v(S_CTRLS, 0, "bubble_ctrls");
    tick();

    // reset during stall
    clr_id();
    bus.id_valid = 1; bus.id_regwrite = 1;
    tick();
    stall = 1; rst = 1;
    expect_v(S_VALID, 0, "rst_in_stall_valid");
    expect_v(S_CTRLS, 0, "rst_in_stall_ctrls");
    tick();
    rst = 0; stall = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
